uart_tx_fifo: RTL

- Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Adds configurable data width, optional odd/even parity, 1 or 2 stop bits, an internal baud divider (no external clken) and a transmit FIFO so software/packet logic can queue bytes.
- Sits between the debug/packet formatter and the board TX pin.
- Frames are sent LSB first, back-to-back while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with FIFO and baud divider; tx falls one edge after the FIFO becomes non-empty.
// Writes while full are dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_50m,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        din,
  input  logic                        wr_en,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx,
  output logic                        tx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d, ovf_q, ovf_d;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, tx_q, tx_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign empty = (count_q == '0);
  assign push  = wr_en && !full_q;
  assign head  = mem_q[rd_ptr_q];

  // FIFO bookkeeping; full is registered so a pop in the same cycle never rescues a write.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CW'(FIFO_DEPTH));
    ovf_d    = wr_en && full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          tx_d    = 1'b0;
          baud_d  = BAUD_LAST;
          state_d = S_START;
        end
      end
      default: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else begin
          baud_d = BAUD_LAST;
          case (state_q)
            S_START: begin
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
              idx_d   = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              if (idx_q == DATA_LAST) begin
                idx_d = '0;
                if (PARITY != 0) begin
                  tx_d    = par_q;
                  state_d = S_PARITY;
                end else begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
                end
              end else begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                idx_d   = idx_q + IW'(1);
              end
            end
            S_PARITY: begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
            S_STOP: begin
              // Chain straight into the next start bit when more data is queued.
              if (idx_q != STOP_LAST) begin
                idx_d = idx_q + IW'(1);
              end else if (!empty) begin
                pop     = 1'b1;
                tx_d    = 1'b0;
                idx_d   = '0;
                state_d = S_START;
              end else begin
                tx_d    = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign full       = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE) || !empty;
endmodule
